// File: rtl/fios_pkg.sv
// Shared definitions for the FIOS operand/result BRAM interface.
//   state_e  : host-port sequencer states
//   block_t  : one 17-bit operand/result block
//   n_base, np0_addr, x_base, y_base, res_base : BRAM word-address map
package fios_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    KICK,
    WAIT,
    READ,
    DRAIN
  } state_e;

  typedef logic [16:0] block_t;

  // n sits at the bottom of the map for every s.
  function automatic int n_base(input int s);
    return s * 0;
  endfunction

  function automatic int np0_addr(input int s);
    return s;
  endfunction

  function automatic int x_base(input int s);
    return s + 1;
  endfunction

  function automatic int y_base(input int s);
    return 2 * s + 1;
  endfunction

  function automatic int res_base();
    return 0;
  endfunction

endpackage

// File: rtl/res_fifo.sv
// Result FIFO: synchronous, parameterized depth, registered storage.
//   clock_i, reset_ni   : clock, async active-low reset
//   push_i, din_i       : write side (ignored when full unless a pop happens too)
//   pop_i, dout_o       : read side, dout_o shows the head entry
//   count_o, empty_o    : occupancy and empty flag
module res_fifo #(
  parameter int WIDTH = 18,
  parameter int DEPTH = 4,
  parameter int CNTW  = $clog2(DEPTH + 1)
) (
  input  logic             clock_i,
  input  logic             reset_ni,
  input  logic             push_i,
  input  logic [WIDTH-1:0] din_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] dout_o,
  output logic [CNTW-1:0]  count_o,
  output logic             empty_o
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]    wr_ptr_q, rd_ptr_q;
  logic             full, do_push, do_pop;

  function automatic logic [PW-1:0] bump(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  assign full    = (count_o == CNTW'(DEPTH));
  assign empty_o = (count_o == '0);
  assign do_pop  = pop_i && !empty_o;
  // a push into a full FIFO is fine when the head leaves in the same cycle
  assign do_push = push_i && (!full || do_pop);
  assign dout_o  = mem_q[rd_ptr_q];

  always_ff @(posedge clock_i or negedge reset_ni) begin
    if (!reset_ni) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_o  <= '0;
    end else begin
      if (do_push) begin
        mem_q[wr_ptr_q] <= din_i;
        wr_ptr_q        <= bump(wr_ptr_q);
      end
      if (do_pop) rd_ptr_q <= bump(rd_ptr_q);
      if (do_push && !do_pop)      count_o <= count_o + CNTW'(1);
      else if (do_pop && !do_push) count_o <= count_o - CNTW'(1);
    end
  end

endmodule

// File: rtl/bram_host_port.sv
// Host port of the FIOS operand/result BRAM.
// Loads the 3s+1 word operand image (n, n_prime_0, X, Y) from a 32-bit
// stream, kicks FIOS, waits for done, then streams the s result blocks out.
//   clock_i, reset_ni            : clock, async active-low reset
//   s_data_i/s_valid_i/s_ready_o : operand word stream
//   m_data_o/m_valid_o/m_ready_i/m_last_o : result block stream
//   fios_start_o, fios_done_i    : FIOS handshake
//   BRAM_*                       : registered BRAM port (read latency RD_LAT)
//   busy_o                       : high outside IDLE
//   err_o                        : sticky format error
// Optional feature: define BRAM_HOST_FMT_CHECK_EN to flag words with
// nonzero bits [31:17]; otherwise err_o is tied low.
//
// state | meaning
// IDLE  | ready for the first operand word
// LOAD  | writing operand words at wcnt
// KICK  | one-cycle FIOS start pulse
// WAIT  | waiting for fios_done_i
// READ  | issuing result reads while credits allow
// DRAIN | waiting for the last block to leave on the m port
module bram_host_port
  import fios_pkg::*;
#(
  parameter int s      = 16,
  parameter int RD_LAT = 2
) (
  input  logic                   clock_i,
  input  logic                   reset_ni,
  input  logic [31:0]            s_data_i,
  input  logic                   s_valid_i,
  output logic                   s_ready_o,
  output logic [16:0]            m_data_o,
  output logic                   m_valid_o,
  input  logic                   m_ready_i,
  output logic                   m_last_o,
  output logic                   fios_start_o,
  input  logic                   fios_done_i,
  output logic                   BRAM_en_o,
  output logic                   BRAM_we_o,
  output logic [$clog2(4*s)-1:0] BRAM_addr_o,
  output logic [31:0]            BRAM_din_o,
  input  logic [31:0]            BRAM_dout_i,
  output logic                   busy_o,
  output logic                   err_o
);

  localparam int AW      = $clog2(4 * s);
  localparam int LAST_WR = y_base(s) + s - 1;
  localparam int DEPTH   = RD_LAT + 2;
  localparam int CNTW    = $clog2(DEPTH + 1);

  state_e          state_q, state_d;
  logic            rdy_en_q;
  logic [AW:0]     wcnt_q;
  logic [AW-1:0]   rcnt_q;
  logic [RD_LAT:0] rd_vld_q, rd_last_q;
  logic            accept, load_done, last_rd, rd_issue, pop;
  logic            fifo_empty;
  logic [17:0]     fifo_dout;
  logic [CNTW-1:0] fifo_count;
  block_t          rd_block;
  int              outstanding;

  logic unused_dout;
  assign unused_dout = ^BRAM_dout_i[31:17];

  assign load_done = (wcnt_q == (AW + 1)'(LAST_WR + 1));
  assign last_rd   = (rcnt_q == AW'(s - 1));
  // rdy_en_q keeps s_ready_o low through the reset cycle
  assign s_ready_o = rdy_en_q && ((state_q == IDLE) || (state_q == LOAD && !load_done));
  assign accept    = s_valid_i && s_ready_o;
  assign busy_o    = (state_q != IDLE);

  assign m_valid_o = !fifo_empty;
  assign m_data_o  = fifo_dout[16:0];
  assign m_last_o  = m_valid_o && fifo_dout[17];
  assign pop       = m_valid_o && m_ready_i;

  // Blocks owed to the FIFO: entries held plus reads still in the BRAM pipe.
  // A pop this cycle frees a slot in time for the next read, so a steady
  // sink sees no bubbles.
  always_comb begin
    outstanding = int'(fifo_count);
    for (int i = 0; i <= RD_LAT; i++) outstanding = outstanding + int'(rd_vld_q[i]);
  end

  assign rd_issue = (state_q == WAIT && fios_done_i) ||
                    (state_q == READ && (outstanding < DEPTH || pop));

  always_ff @(posedge clock_i or negedge reset_ni) begin
    if (!reset_ni) state_q <= IDLE;
    else           state_q <= state_d;
  end

  always_comb begin
    state_d      = state_q;
    fios_start_o = 1'b0;
    unique case (state_q)
      IDLE:  if (accept) state_d = LOAD;
      LOAD:  if (load_done) state_d = KICK;
      KICK: begin
        fios_start_o = 1'b1;
        state_d      = WAIT;
      end
      WAIT:  if (fios_done_i) state_d = last_rd ? DRAIN : READ;
      READ:  if (rd_issue && last_rd) state_d = DRAIN;
      DRAIN: if (pop && m_last_o) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock_i or negedge reset_ni) begin
    if (!reset_ni) begin
      rdy_en_q    <= 1'b0;
      wcnt_q      <= '0;
      rcnt_q      <= '0;
      rd_vld_q    <= '0;
      rd_last_q   <= '0;
      BRAM_en_o   <= 1'b0;
      BRAM_we_o   <= 1'b0;
      BRAM_addr_o <= '0;
      BRAM_din_o  <= '0;
    end else begin
      rdy_en_q  <= 1'b1;
      rd_vld_q  <= {rd_vld_q[RD_LAT-1:0], rd_issue};
      rd_last_q <= {rd_last_q[RD_LAT-1:0], rd_issue && last_rd};
      BRAM_en_o <= accept || rd_issue;
      BRAM_we_o <= accept;
      if (accept) begin
        BRAM_addr_o <= wcnt_q[AW-1:0];
        BRAM_din_o  <= {15'd0, s_data_i[16:0]};
        wcnt_q      <= wcnt_q + (AW + 1)'(1);
      end else if (rd_issue) begin
        BRAM_addr_o <= AW'(res_base()) + rcnt_q;
        rcnt_q      <= rcnt_q + AW'(1);
      end
      if (state_q == KICK) begin
        wcnt_q <= '0;
        rcnt_q <= '0;
      end
    end
  end

  assign rd_block = BRAM_dout_i[16:0];

  res_fifo #(
    .WIDTH (18),
    .DEPTH (DEPTH),
    .CNTW  (CNTW)
  ) u_res_fifo (
    .clock_i  (clock_i),
    .reset_ni (reset_ni),
    .push_i   (rd_vld_q[RD_LAT]),
    .din_i    ({rd_last_q[RD_LAT], rd_block}),
    .pop_i    (pop),
    .dout_o   (fifo_dout),
    .count_o  (fifo_count),
    .empty_o  (fifo_empty)
  );

`ifdef BRAM_HOST_FMT_CHECK_EN
  always_ff @(posedge clock_i or negedge reset_ni) begin
    if (!reset_ni)                           err_o <= 1'b0;
    else if (accept && |s_data_i[31:17])     err_o <= 1'b1;
  end
`else
  logic unused_hi;
  assign unused_hi = ^s_data_i[31:17];
  assign err_o     = 1'b0;
`endif

endmodule

// File: tb/tb_bram_host_port.sv
module tb_bram_host_port;
  import fios_pkg::*;

  localparam int S      = 4;
  localparam int RD_LAT = 2;
  localparam int AW     = $clog2(4 * S);
  localparam int W      = 3 * S + 1;
  localparam int DEPTH  = RD_LAT + 2;
`ifdef BRAM_HOST_FMT_CHECK_EN
  localparam bit FMT_CHK = 1'b1;
`else
  localparam bit FMT_CHK = 1'b0;
`endif
  localparam logic [31:0] DIR_RES [S] = '{32'h0001AAAA, 32'h0000BBBB, 32'h0001CCCC, 32'h0000DDDD};

  logic          clock_i = 1'b0;
  logic          reset_ni;
  logic [31:0]   s_data_i;
  logic          s_valid_i;
  logic          s_ready_o;
  logic [16:0]   m_data_o;
  logic          m_valid_o;
  logic          m_ready_i;
  logic          m_last_o;
  logic          fios_start_o;
  logic          fios_done_i;
  logic          BRAM_en_o;
  logic          BRAM_we_o;
  logic [AW-1:0] BRAM_addr_o;
  logic [31:0]   BRAM_din_o;
  logic [31:0]   BRAM_dout_i;
  logic          busy_o;
  logic          err_o;

  bram_host_port #(.s(S), .RD_LAT(RD_LAT)) dut (
    .clock_i      (clock_i),
    .reset_ni     (reset_ni),
    .s_data_i     (s_data_i),
    .s_valid_i    (s_valid_i),
    .s_ready_o    (s_ready_o),
    .m_data_o     (m_data_o),
    .m_valid_o    (m_valid_o),
    .m_ready_i    (m_ready_i),
    .m_last_o     (m_last_o),
    .fios_start_o (fios_start_o),
    .fios_done_i  (fios_done_i),
    .BRAM_en_o    (BRAM_en_o),
    .BRAM_we_o    (BRAM_we_o),
    .BRAM_addr_o  (BRAM_addr_o),
    .BRAM_din_o   (BRAM_din_o),
    .BRAM_dout_i  (BRAM_dout_i),
    .busy_o       (busy_o),
    .err_o        (err_o)
  );

  always #5 clock_i = ~clock_i;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  always @(posedge clock_i) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h, want 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic fail_msg(input string name);
    checks++;
    failures++;
    $display("FAIL %s (cycle %0d)", name, cyc);
  endtask

  // BRAM behavioural model: registered address, data RD_LAT=2 cycles later.
  logic [31:0] mem [1 << AW];
  logic [31:0] rd1;
  logic        fios_store;
  logic [31:0] res_w [S];
  always @(posedge clock_i) begin
    if (fios_store) for (int i = 0; i < S; i++) mem[i] <= res_w[i];
    if (BRAM_en_o && BRAM_we_o) mem[BRAM_addr_o] <= BRAM_din_o;
    if (BRAM_en_o && !BRAM_we_o) rd1 <= mem[BRAM_addr_o];
    BRAM_dout_i <= rd1;
  end

  typedef struct packed {
    logic [AW-1:0] addr;
    logic [31:0]   din;
  } wr_t;

  wr_t         exp_wr_q [$];
  logic [17:0] exp_out_q [$];
  logic        exp_err;
  int rd_expect, reads_presented, pops_done, outs, starts;
  int first_wr_cyc, last_wr_cyc, final_wr_cyc;
  int first_rd_cyc, first_valid_cyc, first_out_cyc, last_out_cyc;
  int rdy_mode, hold_start;

  initial begin
    starts = 0; final_wr_cyc = -100; rdy_mode = 0; hold_start = 1 << 30;
  end

  always @(posedge clock_i) begin
    #1;
    case (rdy_mode)
      0: m_ready_i = 1'b1;
      1: m_ready_i = (cyc >= hold_start && cyc < hold_start + 10) ? 1'b0 : ((cyc % 2) == 0);
      default: m_ready_i = 1'($urandom_range(0, 1));
    endcase
  end

  always @(negedge clock_i) begin
    if (reset_ni) begin
      if (fios_start_o) begin
        starts++;
        check("start_follows_last_write", 64'(cyc - final_wr_cyc), 64'd1);
      end
      if (BRAM_en_o && BRAM_we_o) begin
        wr_t e;
        if (exp_wr_q.size() == 0) fail_msg("write_unexpected");
        else begin
          e = exp_wr_q.pop_front();
          check("write_addr", 64'(BRAM_addr_o), 64'(e.addr));
          check("write_data", 64'(BRAM_din_o), 64'(e.din));
        end
        if (first_wr_cyc < 0) first_wr_cyc = cyc;
        last_wr_cyc = cyc;
        if (BRAM_addr_o == AW'(W - 1)) final_wr_cyc = cyc;
      end
      if (BRAM_en_o && !BRAM_we_o) begin
        reads_presented++;
        if (rd_expect >= S) fail_msg("read_unexpected");
        else begin
          check("read_addr", 64'(BRAM_addr_o), 64'(rd_expect));
          if (rd_expect == 0) first_rd_cyc = cyc;
          rd_expect++;
        end
        check("read_within_fifo_room", 64'(reads_presented - pops_done <= DEPTH), 64'd1);
      end
      if (m_valid_o && first_valid_cyc < 0) first_valid_cyc = cyc;
      if (m_valid_o && m_ready_i) begin
        if (exp_out_q.size() == 0) fail_msg("output_unexpected");
        else check("out_block", 64'({m_last_o, m_data_o}), 64'(exp_out_q.pop_front()));
        if (outs == 0) first_out_cyc = cyc;
        last_out_cyc = cyc;
        outs++;
        pops_done++;
      end
    end
  end

  task automatic check_reset_outputs(input string tag);
    check({tag, "_s_ready"}, 64'(s_ready_o), 64'd0);
    check({tag, "_outs"}, 64'({m_data_o, m_valid_o, m_last_o, fios_start_o, BRAM_en_o,
                               BRAM_we_o, BRAM_addr_o, BRAM_din_o, busy_o, err_o}), 64'd0);
  endtask

  task automatic send_word(input logic [31:0] w, input int idx);
    int  t;
    wr_t e;
    t = 0;
    s_data_i  = w;
    s_valid_i = 1'b1;
    while (!s_ready_o && t < 50) begin
      @(negedge clock_i);
      t++;
    end
    if (!s_ready_o) begin
      fail_msg("s_ready_timeout");
      s_valid_i = 1'b0;
      return;
    end
    e.addr = AW'(idx);
    e.din  = {15'd0, w[16:0]};
    exp_wr_q.push_back(e);
    if (FMT_CHK && w[31:17] != 15'd0) exp_err = 1'b1;
    @(negedge clock_i);
    s_valid_i = 1'b0;
  endtask

  task automatic run_txn(input int mode, input bit directed, input int bad_pos, input int done_delay);
    logic [31:0] words [W];
    logic [31:0] res [S];
    int t, done_cyc, starts0;
    for (int i = 0; i < W; i++) begin
      if (directed) words[i] = 32'h100 + 32'(i);
      else if ($urandom_range(0, 3) == 0) words[i] = $urandom;
      else words[i] = {15'd0, 17'($urandom)};
    end
    if (bad_pos >= 0) words[bad_pos] = 32'hFFFF_0001;
    for (int i = 0; i < S; i++) res[i] = directed ? DIR_RES[i] : $urandom;
    rd_expect = 0; reads_presented = 0; pops_done = 0; outs = 0;
    first_wr_cyc = -1; first_rd_cyc = -1; first_valid_cyc = -1; first_out_cyc = -1;
    starts0 = starts;
    rdy_mode = mode;
    hold_start = 1 << 30;
    fork
      begin
        for (int i = 0; i < W; i++) begin
          if (!directed) repeat ($urandom_range(0, 2)) @(negedge clock_i);
          send_word(words[i], i);
          if (i == bad_pos) check("err_after_bad_word", 64'(err_o), 64'(exp_err));
        end
      end
      begin
        repeat (4) @(negedge clock_i);
        fios_done_i = 1'b1;
        @(negedge clock_i);
        fios_done_i = 1'b0;
      end
    join
    t = 0;
    while (starts == starts0 && t < 20) begin
      @(negedge clock_i);
      t++;
    end
    if (starts == starts0) fail_msg("start_timeout");
    if (directed) check("writes_back_to_back", 64'(last_wr_cyc - first_wr_cyc), 64'(W - 1));
    for (int i = 0; i < W; i++) check("bram_image", 64'(mem[i]), 64'({15'd0, words[i][16:0]}));
    repeat (done_delay) @(negedge clock_i);
    for (int i = 0; i < S; i++) res_w[i] = res[i];
    fios_store = 1'b1;
    @(negedge clock_i);
    fios_store = 1'b0;
    for (int i = 0; i < S; i++) exp_out_q.push_back({(i == S - 1), res[i][16:0]});
    fios_done_i = 1'b1;
    done_cyc = cyc;
    hold_start = cyc + 6;
    @(negedge clock_i);
    fios_done_i = 1'b0;
    t = 0;
    while (outs < S && t < 300) begin
      @(negedge clock_i);
      t++;
    end
    if (outs < S) fail_msg("output_timeout");
    @(negedge clock_i);
    check("back_to_idle_busy", 64'(busy_o), 64'd0);
    check("back_to_idle_ready", 64'(s_ready_o), 64'd1);
    check("single_start", 64'(starts - starts0), 64'd1);
    check("read_begins_after_done", 64'(first_rd_cyc - done_cyc), 64'd1);
    check("read_count", 64'(rd_expect), 64'(S));
    check("first_output_latency", 64'(first_valid_cyc - first_rd_cyc), 64'(RD_LAT + 1));
    if (mode == 0) check("no_bubbles", 64'(last_out_cyc - first_out_cyc), 64'(S - 1));
    check("err_sticky", 64'(err_o), 64'(exp_err));
    check("out_queue_drained", 64'(exp_out_q.size()), 64'd0);
    rdy_mode = 0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog_timeout");
    failures++;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end

  initial begin
    reset_ni = 1'b0; s_valid_i = 1'b0; s_data_i = '0; fios_done_i = 1'b0;
    fios_store = 1'b0; exp_err = 1'b0;
    for (int i = 0; i < S; i++) res_w[i] = '0;
    repeat (2) @(negedge clock_i);
    check_reset_outputs("reset");
    reset_ni = 1'b1;
    check("ready_low_in_reset_cycle", 64'(s_ready_o), 64'd0);
    @(negedge clock_i);
    check("ready_in_idle", 64'(s_ready_o), 64'd1);

    run_txn(0, 1'b1, -1, 20);
    run_txn(1, 1'b1, -1, 20);
    run_txn(0, 1'b1, 5, 20);

    for (int i = 0; i < 6; i++) send_word(32'h200 + 32'(i), i);
    #2 reset_ni = 1'b0;
    #1 check_reset_outputs("mid_reset");
    exp_wr_q.delete();
    exp_err = 1'b0;
    @(negedge clock_i);
    reset_ni = 1'b1;
    check("ready_low_after_abort", 64'(s_ready_o), 64'd0);
    @(negedge clock_i);
    check("ready_after_abort", 64'(s_ready_o), 64'd1);
    run_txn(0, 1'b1, -1, 20);

    for (int k = 0; k < 6; k++)
      run_txn($urandom_range(0, 2), 1'b0,
              ($urandom_range(0, 3) == 0) ? $urandom_range(0, W - 1) : -1,
              $urandom_range(1, 25));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/bram_host_port.md
# bram_host_port

- Host-side end of the operand/result BRAM interface shared with the FIOS `memory` loader.
- Accepts a 32-bit word stream and writes the operand image into BRAM in layout order: n, n_prime_0, X, Y.
- Pulses the FIOS start, waits for completion, then reads the s result blocks back out of BRAM and streams them out with backpressure.
- Owns the host port of a true dual-port BRAM; `memory` owns the other port.

## Interface
Parameters:
- s, 16, number of 17-bit blocks per operand.
- RD_LAT, 2, BRAM read latency in cycles (address registered to dout valid).

Ports:
- clock_i  in  1  single clock; all logic on its rising edge.
- reset_ni  in  1  asynchronous, active-low reset.
- s_data_i  in  32  operand word; block in bits [16:0].
- s_valid_i  in  1  s_data_i valid.
- s_ready_o  out  1  word accepted when s_valid_i && s_ready_o.
- m_data_o  out  17  result block.
- m_valid_o  out  1  m_data_o valid.
- m_ready_i  in  1  sink ready.
- m_last_o  out  1  high with result block s-1.
- fios_start_o  out  1  one-cycle start pulse to top control.
- fios_done_i  in  1  FIOS computation and result store complete.
- BRAM_en_o  out  1  port enable.
- BRAM_we_o  out  1  write enable.
- BRAM_addr_o  out  $clog2(4*s)  word address.
- BRAM_din_o  out  32  write data, `{15'd0, block}`.
- BRAM_dout_i  in  32  read data; bits [16:0] used.
- busy_o  out  1  high in every state except IDLE.
- err_o  out  1  sticky format error (see Configuration).

## Operation
- Total load length W = 3s+1 words, at addresses 0..3s:
  - n at 0..s-1
  - n_prime_0 at s
  - X at s+1..2s
  - Y at 2s+1..3s
- Result occupies addresses 0..s-1, LSB block first.
- FSM states and transitions:
  - IDLE: s_ready_o=1. The first accepted word is written to address 0 and moves the FSM to LOAD.
  - LOAD: s_ready_o=1. The word counter wcnt addresses each write. After word W-1 is accepted, go to KICK.
  - KICK: s_ready_o=0. fios_start_o=1 for exactly this cycle. Next state is WAIT.
  - WAIT: idle until fios_done_i=1, then go to READ. fios_done_i is ignored in every other state.
  - READ: issue reads of addresses rcnt=0..s-1, one per cycle, only when credits>0. After address s-1 is issued, go to DRAIN.
  - DRAIN: hold until block s-1 has been handshaken on the m port, then go to IDLE.
- Credit flow control:
  - credits = free slots in the result FIFO minus reads still in flight.
  - Results are never dropped under any m_ready_i pattern.
- Input words offered in KICK, WAIT, READ or DRAIN are not accepted, because s_ready_o=0.

## Timing
- Reset values: s_ready_o=0 for the reset cycle, then 1 in IDLE. All other outputs are 0: m_data_o, m_valid_o, m_last_o, fios_start_o, BRAM_en_o, BRAM_we_o, BRAM_addr_o, BRAM_din_o, busy_o, err_o. wcnt, rcnt, credits and the FIFO are cleared.
- BRAM port outputs are registered. An accepted word appears as a write (en=we=1, addr, din) on the cycle after its handshake.
- KICK begins the cycle after the final write is presented, so fios_start_o follows the last write by one cycle.
- Read data is captured into the FIFO RD_LAT cycles after the read is presented. m_valid_o rises the cycle after capture, giving a minimum request-to-output latency of RD_LAT+1.
- With m_ready_i held high, there is one output per cycle and no bubbles after the first.
- FIFO depth is RD_LAT+2.
  - Full: reads stall with BRAM_en_o=0.
  - Empty: m_valid_o=0.
  - Simultaneous push and pop keeps the occupancy unchanged.
- Outside active writes and reads, BRAM_en_o=0 and BRAM_we_o=0.
- Reset asserted mid-operation aborts immediately. Any partial BRAM contents are left as they are; the next load rewrites them from address 0.

## Configuration
- Macro `BRAM_HOST_FMT_CHECK_EN`.
- Defined:
  - Any accepted word with s_data_i[31:17] != 0 sets err_o.
  - err_o stays set until reset.
  - Such a word is still written, masked to `{15'd0, s_data_i[16:0]}`.
- Undefined: err_o is tied to 0 and bits [31:17] are silently masked.

## Structure
- Shared package `fios_pkg` holds:
  - the state enum (IDLE, LOAD, KICK, WAIT, READ, DRAIN)
  - address-map constant functions n_base(s)=0, np0_addr(s)=s, x_base(s)=s+1, y_base(s)=2s+1, res_base=0
  - the 17-bit block typedef
- One sub-module, `res_fifo`: a synchronous FIFO of 17+1 bits (data plus last flag) with parameterized depth, count output and async active-low reset.

## Test plan
- s=4, RD_LAT=2; stream 13 words 0x100..0x10C with s_valid_i held high -> writes land at addresses 0..12 on consecutive cycles; fios_start_o pulses exactly once, one cycle after the address-12 write.
- fios_done_i pulsed during LOAD, then again 20 cycles after KICK -> the early pulse is ignored; reads of addresses 0..3 begin the cycle after the second pulse.
- BRAM model preloaded with result 0x1AAAA,0x0BBBB,0x1CCCC,0x0DDDD, m_ready_i=1 -> m_data_o emits them in order from RD_LAT+1 cycles after the first read; m_last_o is high only with 0x0DDDD; return to IDLE.
- Same as above with m_ready_i toggling 1/0 every cycle and held low for 10 cycles mid-stream -> no loss or duplication; BRAM_en_o drops while the FIFO is full.
- Macro defined; word 0xFFFF_0001 at position 5 -> err_o=1 from the next cycle; address 5 written with 0x0000_0001; err_o still 1 after the transaction completes.
- reset_ni pulsed low after 6 of 13 words -> all outputs return to reset values asynchronously; a fresh 13-word load then completes normally starting at address 0.
